mux_pipe_skid: RTL and testbench
================================

MUX_PIPE_SKID -- requirements
Module: mux_pipe_skid

Interface
REQ-001 Parameter WIDTH, default 32, data width per channel in bits (>=1).
REQ-002 Parameter N, default 4, number of input channels (2..16); SELW = ceil(log2(N)).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 in_data  input  N*WIDTH  packed channels; channel k = in_data[k*WIDTH +: WIDTH].
REQ-006 sel  input  SELW  channel index, sampled with in_valid.
REQ-007 in_valid  input  1  upstream offers a transfer this cycle.
REQ-008 in_ready  output  1  block can accept a transfer; driven from a register only.
REQ-009 flush  input  1  synchronous discard of all buffered entries.
REQ-010 out_data  output  WIDTH  selected, registered data.
REQ-011 out_err  output  1  entry at output was captured with sel >= N.
REQ-012 out_valid  output  1  out_data/out_err hold a valid entry.
REQ-013 out_ready  input  1  downstream accepts the entry this cycle.

Function
REQ-014 Input transfer occurs in a cycle with in_valid=1 and in_ready=1; output transfer occurs with out_valid=1 and out_ready=1.
REQ-015 Captured entry = {data: channel sel of in_data, err: 0} when sel < N; {data: 0, err: 1} when sel >= N.
REQ-016 Storage: one main (output) register and one skid register, each with its own valid bit; total capacity 2 entries.
REQ-017 Latency: an entry accepted in cycle t appears on out_data in cycle t+1 when main is empty or drained in cycle t.
REQ-018 States: EMPTY (main/skid invalid), ONE (main valid, skid invalid), FULL (both valid).
REQ-019 EMPTY: in xfer -> ONE (entry into main); otherwise stay.
REQ-020 ONE: in xfer and out xfer -> ONE, main replaced by new entry; in xfer only -> FULL, new entry into skid; out xfer only -> EMPTY; neither -> stay.
REQ-021 FULL: out xfer -> ONE, skid moves to main; in_ready=0 so no in xfer possible; no out xfer -> stay, both held.
REQ-022 in_ready = 1 in EMPTY and ONE, 0 in FULL, evaluated as registered next-state value (no combinational path from out_ready or in_valid to in_ready).
REQ-023 out_valid = main valid; out_data/out_err = main register contents; outputs stable while out_valid=1 and out_ready=0.
REQ-024 Ordering strictly FIFO; no entry duplicated or dropped except by flush/reset.
REQ-025 Sustained throughput: one transfer per cycle when in_valid=1 and out_ready=1 continuously.
REQ-026 flush=1: next state EMPTY, in_ready=1 next cycle; any same-cycle input transfer is discarded; flush has priority over all transfers.
REQ-027 out_data/out_err when out_valid=0 are don't-care for the consumer but shall be 0 after reset or flush.
REQ-028 sel changes while in_ready=0 have no effect; selection uses only the sel value in the transfer cycle.

Reset
REQ-029 rst_n=0 at a rising edge: state EMPTY, out_valid=0, out_data=0, out_err=0, in_ready=1 from the next cycle.
REQ-030 Reset mid-operation discards all entries regardless of in_valid/out_ready/flush; reset has priority over flush.
REQ-031 in_ready=1 after reset even while rst_n remains 0; transfers attempted while rst_n=0 are ignored.

Verification
REQ-032 WIDTH=32,N=4; in_data channels {A0,B1,C2,D3}, sel=2, in_valid=1, out_ready=1 one cycle -> next cycle out_valid=1, out_data=C2, out_err=0.
REQ-033 N=3; sel=3 with in_valid=1 -> entry out_data=0, out_err=1.
REQ-034 out_ready=0, push 0x11,0x22 back-to-back -> in_ready=0 after second push, out_data holds 0x11; release out_ready -> 0x11 then 0x22 on consecutive cycles, in_ready=1 after first drain.
REQ-035 Stream 0x01..0x10 with in_valid=out_ready=1 every cycle -> 16 outputs in order, one per cycle, in_ready never 0.
REQ-036 FULL state, assert flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, out_data=0; flushed and same-cycle entries never appear.
REQ-037 FULL state, drop rst_n for 1 cycle -> out_valid=0, out_err=0, in_ready=1; subsequent push 0x5A emerges after 1 cycle.

Source files
------------

// File: rtl/mux_pipe_skid.sv
// -----------------------------------------------------------------------------
// mux_pipe_skid
//   Selects one of N packed input channels and delivers the chosen word through
//   a two-entry pipeline (main output register + skid register) with
//   valid/ready handshakes on both sides. An entry captured with an
//   out-of-range select carries zero data and err=1. in_ready is a pure
//   register output, so there is no combinational path from out_ready or
//   in_valid back to the upstream side.
//
// Parameters
//   WIDTH  data width per channel (>= 1)
//   N      number of input channels (2..16); SELW = ceil(log2(N))
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset (priority over flush)
//   in_data    N*WIDTH packed channels, channel k = in_data[k*WIDTH +: WIDTH]
//   sel        channel index, sampled only in an input transfer cycle
//   in_valid   upstream offers an entry
//   in_ready   block can accept an entry (registered)
//   flush      synchronous discard of all buffered entries
//   out_data   registered selected data
//   out_err    entry at the output was captured with sel >= N
//   out_valid  out_data/out_err hold a valid entry
//   out_ready  downstream accepts the entry this cycle
// -----------------------------------------------------------------------------
module mux_pipe_skid #(
  parameter  int WIDTH = 32,
  parameter  int N     = 4,
  localparam int SELW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [SELW-1:0]      sel,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 flush,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_err,
  output logic                 out_valid,
  input  logic                 out_ready
);

  // Bit 0 = main register valid, bit 1 = skid register valid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b11
  } state_e;

  localparam logic [SELW:0] NUM_CH = (SELW + 1)'(N);

  state_e             state_q;
  logic               in_ready_q;
  logic [WIDTH-1:0]   main_data_q;
  logic               main_err_q;
  logic [WIDTH-1:0]   skid_data_q;
  logic               skid_err_q;

  logic [WIDTH-1:0]   cap_data;
  logic               cap_err;
  logic               in_xfer;
  logic               out_xfer;
  logic               skid_load;

  // Channel selection for the entry that would be captured this cycle.
  // NOTE: every signal assigned in always_comb gets a default first, otherwise
  // an unmatched select leaves it holding its old value and a latch is inferred.
  always_comb begin
    cap_data = '0;
    for (int k = 0; k < N; k++) begin
      if ({1'b0, sel} == k[SELW:0]) cap_data = in_data[k*WIDTH +: WIDTH];
    end
    cap_err = ({1'b0, sel} >= NUM_CH);
  end

  assign in_xfer   = in_valid & in_ready_q;
  assign out_xfer  = state_q[0] & out_ready;
  assign skid_load = (state_q == ST_ONE) & in_xfer & ~out_xfer;

  // Control FSM plus the main output register. The next in_ready is computed
  // from the next state so it can be driven straight from a flop.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
    end else if (flush) begin
      state_q     <= ST_EMPTY;
      in_ready_q  <= 1'b1;
      main_data_q <= '0;
      main_err_q  <= 1'b0;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_q     <= ST_ONE;
            main_data_q <= cap_data;
            main_err_q  <= cap_err;
          end
        end
        ST_ONE: begin
          if (in_xfer && out_xfer) begin
            main_data_q <= cap_data;
            main_err_q  <= cap_err;
          end else if (in_xfer) begin
            state_q    <= ST_FULL;
            in_ready_q <= 1'b0;
          end else if (out_xfer) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is 0 here, so only the output side can move.
          if (out_xfer) begin
            state_q     <= ST_ONE;
            in_ready_q  <= 1'b1;
            main_data_q <= skid_data_q;
            main_err_q  <= skid_err_q;
          end
        end
        default: begin
          state_q    <= ST_EMPTY;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

  // Skid storage is only read while its valid bit (state_q[1]) is set, which
  // reset and flush clear, so its contents need no reset.
  // NOTE: pure data storage is left out of reset on purpose; only the valid
  // tracking must be reset to make stale contents unobservable.
  always_ff @(posedge clk) begin
    if (skid_load) begin
      skid_data_q <= cap_data;
      skid_err_q  <= cap_err;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = state_q[0];
  assign out_data  = main_data_q;
  assign out_err   = main_err_q;

endmodule

// File: tb/tb_mux_pipe_skid.sv
// -----------------------------------------------------------------------------
// tb_mux_pipe_skid
//   Directed plus randomized stimulus for mux_pipe_skid (WIDTH=32, N=4), with a
//   queue-based scoreboard of accepted entries, and a second instance (N=3)
//   exercising the out-of-range select path.
// -----------------------------------------------------------------------------
module tb_mux_pipe_skid;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } entry_t;

  logic         clk;
  logic         rst_n;
  logic         flush;

  logic [127:0] in_data;
  logic [1:0]   sel;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_err;
  logic         out_valid;
  logic         out_ready;

  logic [95:0]  in_data3;
  logic [1:0]   sel3;
  logic         in_valid3;
  logic         in_ready3;
  logic [31:0]  out_data3;
  logic         out_err3;
  logic         out_valid3;
  logic         out_ready3;

  int checks = 0;
  int errors = 0;
  entry_t sb_q[$];

  mux_pipe_skid #(.WIDTH(32), .N(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .sel       (sel),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_data  (out_data),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  mux_pipe_skid #(.WIDTH(32), .N(3)) u_dut3 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data3),
    .sel       (sel3),
    .in_valid  (in_valid3),
    .in_ready  (in_ready3),
    .flush     (flush),
    .out_data  (out_data3),
    .out_err   (out_err3),
    .out_valid (out_valid3),
    .out_ready (out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock on the N=4 instance: decide from the model which
  // transfers happen at this edge, update the scoreboard, then compare.
  task automatic cycle(input string tag);
    bit     ix;
    bit     ox;
    bit     cleared;
    entry_t e;
    logic [127:0] shifted;
    ix        = in_valid && (sb_q.size() < 2);
    ox        = out_ready && (sb_q.size() > 0);
    shifted   = in_data >> (32 * int'(sel));
    e.data    = shifted[31:0];
    e.err     = 1'b0;
    cleared   = !rst_n || flush;
    @(posedge clk);
    #1;
    if (cleared) begin
      sb_q.delete();
    end else begin
      if (ox) void'(sb_q.pop_front());
      if (ix) sb_q.push_back(e);
    end
    check({tag, ".out_valid"}, 64'(out_valid), 64'(sb_q.size() > 0));
    check({tag, ".in_ready"},  64'(in_ready),  64'(sb_q.size() < 2));
    if (sb_q.size() > 0) begin
      check({tag, ".out_data"}, 64'(out_data), 64'(sb_q[0].data));
      check({tag, ".out_err"},  64'(out_err),  64'(sb_q[0].err));
    end
    if (cleared) begin
      check({tag, ".clr_data"}, 64'(out_data), 64'h0);
      check({tag, ".clr_err"},  64'(out_err),  64'h0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    flush      = 1'b0;
    in_data    = {32'hD3, 32'hC2, 32'hB1, 32'hA0};
    sel        = 2'd1;
    in_valid   = 1'b1;
    out_ready  = 1'b0;
    in_data3   = '0;
    sel3       = 2'd0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;

    // Reset held for two edges with a transfer offered: it must be ignored.
    cycle("rst0");
    cycle("rst1");
    check("rst.out_valid3", 64'(out_valid3), 64'h0);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    cycle("idle");

    // Single entry from channel 2, visible one cycle later.
    in_valid  = 1'b1;
    sel       = 2'd2;
    out_ready = 1'b1;
    cycle("c2_push");
    in_valid = 1'b0;
    check("c2.out_data", 64'(out_data), 64'hC2);
    check("c2.out_err",  64'(out_err),  64'h0);
    cycle("c2_drain");

    // Back-to-back pushes with the consumer stalled fill main and skid.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h0, 32'h0, 32'h22, 32'h11};
    sel       = 2'd0;
    cycle("bp_push1");
    sel = 2'd1;
    cycle("bp_push2");
    check("bp.full_ready", 64'(in_ready), 64'h0);
    // Changing sel while stalled must have no effect.
    in_data = {32'hEE, 32'hEE, 32'hEE, 32'hEE};
    sel     = 2'd3;
    cycle("bp_hold1");
    in_valid = 1'b0;
    cycle("bp_hold2");
    check("bp.hold_data", 64'(out_data), 64'h11);
    out_ready = 1'b1;
    cycle("bp_drain1");
    check("bp.second", 64'(out_data), 64'h22);
    check("bp.ready_after", 64'(in_ready), 64'h1);
    cycle("bp_drain2");

    // Sustained stream: one accepted and one delivered entry per cycle.
    in_valid = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      sel     = 2'($urandom_range(0, 3));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      in_data[32*int'(sel) +: 32] = 32'(i);
      cycle("stream");
      check("stream.ready", 64'(in_ready), 64'h1);
      check("stream.data",  64'(out_data), 64'(i));
    end
    in_valid = 1'b0;
    cycle("stream_tail");

    // Flush from FULL with a simultaneous transfer offered.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h44, 32'h33, 32'h22, 32'h11};
    sel       = 2'd2;
    cycle("fl_fill1");
    sel = 2'd3;
    cycle("fl_fill2");
    flush = 1'b1;
    sel   = 2'd0;
    cycle("flush");
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle("fl_after1");
    cycle("fl_after2");

    // One-cycle reset from FULL, then a fresh push.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = {32'h7, 32'h6, 32'h5, 32'h4};
    sel       = 2'd1;
    cycle("rs_fill1");
    cycle("rs_fill2");
    rst_n = 1'b0;
    cycle("rs_pulse");
    rst_n     = 1'b1;
    out_ready = 1'b1;
    in_data   = {32'h0, 32'h5A, 32'h0, 32'h0};
    sel       = 2'd2;
    cycle("rs_push");
    in_valid = 1'b0;
    check("rs.5a", 64'(out_data), 64'h5A);
    cycle("rs_drain");

    // Randomized traffic with occasional flush.
    for (int i = 0; i < 300; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      sel       = 2'($urandom_range(0, 3));
      in_data   = {$urandom, $urandom, $urandom, $urandom};
      cycle("rand");
    end
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle("rand_drain1");
    cycle("rand_drain2");

    // N=3 instance: in-range then out-of-range select.
    in_data3  = {32'h33, 32'h22, 32'h11};
    sel3      = 2'd1;
    in_valid3 = 1'b1;
    cycle("n3_push1");
    check("n3.valid1", 64'(out_valid3), 64'h1);
    check("n3.data1",  64'(out_data3),  64'h22);
    check("n3.err1",   64'(out_err3),   64'h0);
    sel3 = 2'd3;
    cycle("n3_push2");
    in_valid3 = 1'b0;
    check("n3.valid2", 64'(out_valid3), 64'h1);
    check("n3.data2",  64'(out_data3),  64'h0);
    check("n3.err2",   64'(out_err3),   64'h1);
    cycle("n3_drain");
    check("n3.valid3", 64'(out_valid3), 64'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
